// File: rtl/regfile_sb.sv
// Integer register file with per-register outstanding-write counters.
// Two bypassed combinational read ports, one WB write port, RAW/saturation issue stall.
module regfile_sb #(
  parameter int NREG   = 32,
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            reg_write_enable_i,
  input  logic [4:0]      write_addr_i,
  input  logic [XLEN-1:0] write_data_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            issue_valid_i,
  input  logic            issue_wen_i,
  input  logic [4:0]      issue_dest_i,
  output logic            issue_stall_o,
  input  logic            flush_i,
  output logic            sb_err_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  logic            wr_valid;
  logic            accept;
  logic            issue_stall;
  logic            sb_err_q, sb_err_d;
  logic [XLEN-1:0] reg_view [NREG];
  logic [NREG-1:0] pend_nz;
  logic [NREG-1:0] cnt_max;
  logic [NREG-1:0] cnt_zero;

  assign wr_valid = rst_ni && reg_write_enable_i && (write_addr_i != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_view[gi] = '0;
        assign pend_nz[gi]  = 1'b0;
        assign cnt_max[gi]  = 1'b0;
        assign cnt_zero[gi] = 1'b1;
      end else begin : g_live
        logic [XLEN-1:0]   data_q;
        logic [PEND_W-1:0] cnt_q, cnt_d;
        logic              wr_hit, inc, dec;

        assign wr_hit = wr_valid && (write_addr_i == 5'(gi));
        assign inc    = accept && issue_wen_i && (issue_dest_i == 5'(gi));
        assign dec    = wr_hit && (cnt_q != '0);

        // Simultaneous inc and dec cancel; flush overrides both.
        always_comb begin
          cnt_d = cnt_q;
          if (flush_i)          cnt_d = '0;
          else if (inc && !dec) cnt_d = cnt_q + PEND_W'(1);
          else if (dec && !inc) cnt_d = cnt_q - PEND_W'(1);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
          end else begin
            if (wr_hit) data_q <= write_data_i;
            cnt_q <= cnt_d;
          end
        end

        assign reg_view[gi] = data_q;
        // Pending after discounting a write landing this cycle, floored at zero.
        assign pend_nz[gi]  = (cnt_q > PEND_W'(1)) || ((cnt_q == PEND_W'(1)) && !wr_hit);
        assign cnt_max[gi]  = (cnt_q == {PEND_W{1'b1}});
        assign cnt_zero[gi] = (cnt_q == '0);
      end
    end
  endgenerate

  assign rdata1_o = !rst_ni ? '0 :
                    (wr_valid && (write_addr_i == raddr1_i)) ? write_data_i : reg_view[raddr1_i];
  assign rdata2_o = !rst_ni ? '0 :
                    (wr_valid && (write_addr_i == raddr2_i)) ? write_data_i : reg_view[raddr2_i];
  assign dbg_data_o = !rst_ni ? '0 : reg_view[dbg_addr_i];

  assign issue_stall = rst_ni && issue_valid_i &&
                       ((rs1_used_i && pend_nz[raddr1_i]) ||
                        (rs2_used_i && pend_nz[raddr2_i]) ||
                        (issue_wen_i && (issue_dest_i != 5'd0) && cnt_max[issue_dest_i]));
  assign accept        = issue_valid_i && !issue_stall && !flush_i;
  assign issue_stall_o = issue_stall;

  assign sb_err_d = sb_err_q || (wr_valid && !flush_i && cnt_zero[write_addr_i]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sb_err_q <= 1'b0;
    else         sb_err_q <= sb_err_d;
  end

  assign sb_err_o = sb_err_q;

endmodule
